// File: rtl/delay_arb_pkg.sv
// Shared types and constants for the delay arbiter.
// The optional abort path is controlled by DELAY_ARBITER_ABORT_EN in delay_arbiter.sv.
package delay_arb_pkg;

    localparam int DEFAULT_N     = 2500;
    localparam int DEFAULT_CBITS = 12;
    localparam int MAX_NREQ      = 16;
    localparam int IDXW          = 4;

    // Two-hot-free encoding so illegal values are detectable and recoverable.
    typedef enum logic [1:0] {
        IDLE  = 2'b01,
        COUNT = 2'b10
    } state_t;

    function automatic logic [MAX_NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
        return MAX_NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/delay_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit strictly after ptr, wrapping.
module delay_arb_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   idx,
    output logic            valid
);

    logic [PW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest set bit wins last.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = PW'((int'(ptr) + k) % NREQ);
            if (req[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/delay_arbiter.sv
// Round-robin arbiter sharing one programmable delay counter among NREQ requesters.
// Define DELAY_ARBITER_ABORT_EN to end a grant early when its owner drops req.
module delay_arbiter
    import delay_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int CBITS = DEFAULT_CBITS,
    parameter int N     = DEFAULT_N,
    parameter int PW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CBITS-1:0] dly,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  sig,
    output logic                  abrt,
    output logic                  busy,
    output logic                  err
);

    state_t           state;
    logic [CBITS-1:0] cnt;
    logic [CBITS-1:0] limit;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    pick_idx;
    logic             pick_valid;
    logic [CBITS-1:0] dly_a [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_dly
        assign dly_a[i] = dly[i*CBITS +: CBITS];
    end

    delay_arb_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign busy = (state == COUNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            limit <= '0;
            ptr   <= PW'(NREQ - 1);
            grant <= '0;
            done  <= '0;
            sig   <= 1'b0;
            abrt  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= '0;
            sig  <= 1'b0;
            abrt <= 1'b0;
            case (state)
                IDLE: begin
                    grant <= '0;
                    if (pick_valid) begin
                        grant <= NREQ'(onehot(IDXW'(pick_idx)));
                        ptr   <= pick_idx;
                        cnt   <= '0;
                        limit <= (dly_a[pick_idx] == '0) ? CBITS'(N) : dly_a[pick_idx];
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (cnt > limit || !$onehot(grant))
                        err <= 1'b1;
                    // An overrun counter can never meet limit again; drop the grant.
                    if (cnt > limit) begin
                        grant <= '0;
                        cnt   <= '0;
                        state <= IDLE;
                    end
`ifdef DELAY_ARBITER_ABORT_EN
                    else if (!req[ptr]) begin
                        abrt  <= 1'b1;
                        grant <= '0;
                        cnt   <= '0;
                        state <= IDLE;
                    end
`endif
                    else if (cnt == limit) begin
                        done  <= NREQ'(onehot(IDXW'(ptr)));
                        sig   <= 1'b1;
                        grant <= '0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    err   <= 1'b1;
                    grant <= '0;
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
